// File: rtl/fifo_unpack_pkg.sv
// Shared types, byte-lane constants and ring pointer arithmetic for the
// 24-in / 16-out byte-ring unpacker.
package fifo_unpack_pkg;

  typedef logic [7:0] byte_t;

  // Bytes consumed per write word and produced per read word.
  localparam int WR_BYTES = 3;
  localparam int RD_BYTES = 2;

  // Advance a ring pointer by n bytes; size must be a power of two.
  function automatic int unsigned ring_add(input int unsigned ptr,
                                           input int unsigned n,
                                           input int unsigned size);
    return (ptr + n) & (size - 1);
  endfunction

endpackage

// File: rtl/fifo_byte_ram.sv
// Byte-wide ring storage: one 3-byte write port and one 2-byte asynchronous
// read port. Every byte lane wraps its own address, so a word may straddle
// the end of the ring. Contents are never reset.
module fifo_byte_ram
  import fifo_unpack_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk143,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_addr1, wr_addr2, rd_addr1;

  // Per-byte wrapped addresses for the upper lanes of each port.
  always_comb begin
    wr_addr1 = AW'(ring_add(32'(wr_addr), 1, DEPTH));
    wr_addr2 = AW'(ring_add(32'(wr_addr), 2, DEPTH));
    rd_addr1 = AW'(ring_add(32'(rd_addr), 1, DEPTH));
  end

  // Store the three bytes of an accepted write, oldest byte at wr_addr.
  always_ff @(posedge clk143) begin
    if (wr_en) begin
      mem_q[wr_addr]  <= wr_data[7:0];
      mem_q[wr_addr1] <= wr_data[15:8];
      mem_q[wr_addr2] <= wr_data[23:16];
    end
  end

  assign rd_data = {mem_q[rd_addr1], mem_q[rd_addr]};

endmodule

// File: rtl/fifo_unpacker.sv
// Width-converting byte-ring FIFO: 24-bit writes in, 16-bit pops out, with
// registered full/empty/watermark flags derived from the next byte count.
// Optional error reporting (ovf, udf, drop_cnt) is enabled by defining
// FIFO_UNPACK_ERR_EN.
module fifo_unpacker
  import fifo_unpack_pkg::*;
#(
  parameter int BUF_BYTES = 512,
  parameter int HW_LEVEL  = 384,
  parameter int LW_LEVEL  = 128
) (
  input  logic                       clk143,
  input  logic                       reset_n,
  input  logic                       we,
  input  logic [23:0]                din,
  output logic                       full,
  input  logic                       pop,
  output logic [15:0]                dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       buf_hw,
  output logic                       buf_lw,
  output logic [$clog2(BUF_BYTES):0] count
`ifdef FIFO_UNPACK_ERR_EN
  ,
  output logic                       ovf,
  output logic                       udf,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(BUF_BYTES);
  localparam int CW = AW + 1;
  // Highest count that still leaves room for a whole write word.
  localparam logic [CW-1:0] WR_MAX = CW'(BUF_BYTES - WR_BYTES);
  localparam logic [CW-1:0] RD_MIN = CW'(RD_BYTES);
  localparam logic [CW-1:0] HW_MIN = CW'(HW_LEVEL);
  localparam logic [CW-1:0] LW_MAX = CW'(LW_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   dout_q, dout_d, ram_rd_data;
  logic          dout_valid_q, dout_valid_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          buf_hw_q, buf_hw_d, buf_lw_q, buf_lw_d;
  logic          wr_ok, rd_ok;

  fifo_byte_ram #(
    .DEPTH (BUF_BYTES),
    .AW    (AW)
  ) u_ram (
    .clk143  (clk143),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // Accept decisions use the pre-edge count only, so a same-cycle pop never
  // frees room for a write and never returns the bytes being written.
  always_comb begin
    wr_ok        = we  && (count_q <= WR_MAX);
    rd_ok        = pop && (count_q >= RD_MIN);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (wr_ok) begin
      wr_ptr_d = AW'(ring_add(32'(wr_ptr_q), WR_BYTES, BUF_BYTES));
      count_d  = count_d + CW'(WR_BYTES);
    end
    if (rd_ok) begin
      rd_ptr_d     = AW'(ring_add(32'(rd_ptr_q), RD_BYTES, BUF_BYTES));
      count_d      = count_d - CW'(RD_BYTES);
      dout_d       = ram_rd_data;
      dout_valid_d = 1'b1;
    end
    full_d   = count_d > WR_MAX;
    empty_d  = count_d < RD_MIN;
    buf_hw_d = count_d >= HW_MIN;
    buf_lw_d = count_d <= LW_MAX;
  end

  // State and flag registers; reset discards all buffered data.
  always_ff @(posedge clk143) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      buf_hw_q     <= 1'b0;
      buf_lw_q     <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      buf_hw_q     <= buf_hw_d;
      buf_lw_q     <= buf_lw_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign buf_hw     = buf_hw_q;
  assign buf_lw     = buf_lw_q;
  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef FIFO_UNPACK_ERR_EN
  logic        ovf_q, ovf_d, udf_q, udf_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Sticky overflow/underflow and a saturating count of dropped writes.
  always_comb begin
    ovf_d      = ovf_q || (we && !wr_ok);
    udf_d      = udf_q || (pop && !rd_ok);
    drop_cnt_d = drop_cnt_q;
    if (we && !wr_ok && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Error registers are cleared only by reset.
  always_ff @(posedge clk143) begin
    if (!reset_n) begin
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker. A byte-queue model tracks the
// expected stream; each scenario task compares DUT outputs against it.
// Define FIFO_UNPACK_ERR_EN to also exercise ovf/udf/drop_cnt.
module tb_fifo_unpacker;

  localparam int BUF = 512;

  logic        clk143 = 1'b0;
  logic        reset_n = 1'b0;
  logic        we = 1'b0;
  logic        pop = 1'b0;
  logic [23:0] din = '0;
  logic        full, dout_valid, empty, buf_hw, buf_lw;
  logic [15:0] dout;
  logic [9:0]  count;
`ifdef FIFO_UNPACK_ERR_EN
  logic        ovf, udf;
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  model_q[$];
  logic [15:0] exp_dout;
  logic        exp_valid;
  logic        exp_ovf, exp_udf;
  int          exp_drop;

  always #5 clk143 = ~clk143;

  fifo_unpacker #(
    .BUF_BYTES (512),
    .HW_LEVEL  (384),
    .LW_LEVEL  (128)
  ) dut (
    .clk143     (clk143),
    .reset_n    (reset_n),
    .we         (we),
    .din        (din),
    .full       (full),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .buf_hw     (buf_hw),
    .buf_lw     (buf_lw),
    .count      (count)
`ifdef FIFO_UNPACK_ERR_EN
    ,
    .ovf        (ovf),
    .udf        (udf),
    .drop_cnt   (drop_cnt)
`endif
  );

  // One clock with the given inputs; the model follows the byte-stream rules.
  task automatic step(input logic w, input logic [23:0] d, input logic p);
    bit wr_ok, rd_ok;
    we = w; din = d; pop = p;
    @(posedge clk143);
    wr_ok = w && ((BUF - model_q.size()) >= 3);
    rd_ok = p && (model_q.size() >= 2);
    exp_valid = rd_ok;
    if (rd_ok) begin
      exp_dout[7:0]  = model_q.pop_front();
      exp_dout[15:8] = model_q.pop_front();
    end
    if (wr_ok) begin
      model_q.push_back(d[7:0]);
      model_q.push_back(d[15:8]);
      model_q.push_back(d[23:16]);
    end
    if (w && !wr_ok) begin
      exp_ovf = 1'b1;
      if (exp_drop < 65535) exp_drop++;
    end
    if (p && !rd_ok) exp_udf = 1'b1;
    #1;
    we = 1'b0; pop = 1'b0;
  endtask

  // Reset edge, optionally with write/pop also held high.
  task automatic do_reset(input logic w, input logic [23:0] d, input logic p);
    reset_n = 1'b0; we = w; din = d; pop = p;
    @(posedge clk143);
    model_q.delete();
    exp_dout = '0; exp_valid = 1'b0;
    exp_ovf = 1'b0; exp_udf = 1'b0; exp_drop = 0;
    #1;
    reset_n = 1'b1; we = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, '0, 1'b0);
    checks += 7;
    if (count !== 10'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
    if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    if (buf_hw !== 1'b0) begin failures++; $display("[TB] FAIL reset_hw got=%b exp=0", buf_hw); end
    if (buf_lw !== 1'b1) begin failures++; $display("[TB] FAIL reset_lw got=%b exp=1", buf_lw); end
    if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", dout_valid); end
    if (dout !== 16'h0) begin failures++; $display("[TB] FAIL reset_dout got=%h exp=0000", dout); end
    // Pop while empty is ignored.
    step(1'b0, '0, 1'b1);
    checks += 2;
    if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL empty_pop_valid got=%b exp=0", dout_valid); end
    if (count !== 10'd0) begin failures++; $display("[TB] FAIL empty_pop_count got=%0d exp=0", count); end
`ifdef FIFO_UNPACK_ERR_EN
    checks++;
    if (udf !== 1'b1) begin failures++; $display("[TB] FAIL udf got=%b exp=1", udf); end
`endif
  endtask

  task automatic test_basic();
    logic [15:0] golden [3];
    golden[0] = 16'hBBAA; golden[1] = 16'hDDCC; golden[2] = 16'hFFEE;
    do_reset(1'b0, '0, 1'b0);
    step(1'b1, 24'hCCBBAA, 1'b0);
    step(1'b1, 24'hFFEEDD, 1'b0);
    checks++;
    if (count !== 10'd6) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=6", count); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1);
      checks += 2;
      if (dout_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid%0d got=%b exp=1", i, dout_valid); end
      if (dout !== golden[i]) begin failures++; $display("[TB] FAIL basic_dout%0d got=%h exp=%h", i, dout, golden[i]); end
    end
    step(1'b0, '0, 1'b0);
    checks += 3;
    if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_idle_valid got=%b exp=0", dout_valid); end
    if (dout !== 16'hFFEE) begin failures++; $display("[TB] FAIL basic_hold got=%h exp=ffee", dout); end
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL basic_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill();
    do_reset(1'b0, '0, 1'b0);
    for (int i = 1; i <= 170; i++) begin
      step(1'b1, 24'($urandom), 1'b0);
      checks++;
      if (count !== 10'(3 * i)) begin failures++; $display("[TB] FAIL fill_count%0d got=%0d exp=%0d", i, count, 3 * i); end
    end
    checks += 2;
    if (full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full got=%b exp=1", full); end
    if (buf_hw !== 1'b1) begin failures++; $display("[TB] FAIL fill_hw got=%b exp=1", buf_hw); end
    step(1'b1, 24'($urandom), 1'b0);
    checks++;
    if (count !== 10'd510) begin failures++; $display("[TB] FAIL fill_drop_count got=%0d exp=510", count); end
`ifdef FIFO_UNPACK_ERR_EN
    checks += 2;
    if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf got=%b exp=1", ovf); end
    if (drop_cnt !== 16'd1) begin failures++; $display("[TB] FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
    // Drain and verify the stored stream.
    for (int i = 0; i < 255; i++) begin
      step(1'b0, '0, 1'b1);
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp_dout) begin
        failures++; $display("[TB] FAIL fill_drain%0d got=%b/%h exp=1/%h", i, dout_valid, dout, exp_dout);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    b = 8'h00;
    do_reset(1'b0, '0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 171; i++) begin
        step(1'b1, {b + 8'd2, b + 8'd1, b}, 1'b0);
        b = b + 8'd3;
      end
      for (int i = 0; i < 255; i++) begin
        step(1'b0, '0, 1'b1);
        checks++;
        if (dout_valid !== exp_valid || (exp_valid && dout !== exp_dout)) begin
          failures++; $display("[TB] FAIL wrap_r%0d_p%0d got=%b/%h exp=%b/%h", r, i, dout_valid, dout, exp_valid, exp_dout);
        end
      end
      checks++;
      if (count !== 10'(model_q.size())) begin failures++; $display("[TB] FAIL wrap_count%0d got=%0d exp=%0d", r, count, model_q.size()); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0, '0, 1'b0);
    step(1'b1, 24'($urandom), 1'b0);
    step(1'b1, 24'($urandom), 1'b0);
    step(1'b0, '0, 1'b1);
    checks++;
    if (count !== 10'd4) begin failures++; $display("[TB] FAIL b2b_start got=%0d exp=4", count); end
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 24'($urandom), 1'b1);
      checks += 2;
      if (count !== 10'(4 + i)) begin failures++; $display("[TB] FAIL b2b_count%0d got=%0d exp=%0d", i, count, 4 + i); end
      if (dout_valid !== 1'b1 || dout !== exp_dout) begin
        failures++; $display("[TB] FAIL b2b_dout%0d got=%b/%h exp=1/%h", i, dout_valid, dout, exp_dout);
      end
    end
  endtask

  task automatic test_watermarks();
    do_reset(1'b0, '0, 1'b0);
    for (int i = 1; i <= 130; i++) begin
      step(1'b1, 24'($urandom), 1'b0);
      checks += 3;
      if (buf_lw !== ((3 * i) <= 128)) begin failures++; $display("[TB] FAIL lw_at%0d got=%b exp=%b", 3 * i, buf_lw, (3 * i) <= 128); end
      if (buf_hw !== ((3 * i) >= 384)) begin failures++; $display("[TB] FAIL hw_at%0d got=%b exp=%b", 3 * i, buf_hw, (3 * i) >= 384); end
      if (empty !== 1'b0) begin failures++; $display("[TB] FAIL wm_empty%0d got=%b exp=0", i, empty); end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 24'($urandom), 1'b0);
    checks++;
    if (count !== 10'd300) begin failures++; $display("[TB] FAIL mid_pre got=%0d exp=300", count); end
    do_reset(1'b1, 24'($urandom), 1'b1);
    checks += 4;
    if (count !== 10'd0) begin failures++; $display("[TB] FAIL mid_count got=%0d exp=0", count); end
    if (empty !== 1'b1) begin failures++; $display("[TB] FAIL mid_empty got=%b exp=1", empty); end
    if (buf_lw !== 1'b1) begin failures++; $display("[TB] FAIL mid_lw got=%b exp=1", buf_lw); end
    if (dout_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got=%b exp=0", dout_valid); end
    step(1'b1, 24'h123456, 1'b0);
    step(1'b0, '0, 1'b1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'h3456) begin
      failures++; $display("[TB] FAIL mid_new got=%b/%h exp=1/3456", dout_valid, dout);
    end
  endtask

  initial begin
    $display("[TB] fifo_unpacker bench start");
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_watermarks();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
